// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data memory responder: word width,
// responder FSM state encoding and response error codes.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Values driven on resp_error
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x WORD_W word storage: synchronous write port and combinational
// read port sharing one index. Contents are intentionally not reset.
module mem_word_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_reg [DEPTH];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[index] <= wdata;
        end
    end

    assign rdata = mem_reg[index];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one word request over a valid/ready
// channel, waits LATENCY edges, performs the access and holds the
// response on a valid/ready channel until the initiator takes it.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_error
);

    localparam int IDX_W = $clog2(DEPTH);
    // Counter only has to hold LATENCY-1; keep at least one bit
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              write_reg;
    logic [IDX_W-1:0]  index_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic              err_reg;
    logic              resp_valid_reg;
    logic [WORD_W-1:0] resp_rdata_reg;
    logic              resp_error_reg;

    logic [IDX_W-1:0]  req_index;
    logic              req_err;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // Word index and range/alignment check on the incoming byte address
    assign req_index = req_addr[IDX_W+1:2];
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);

    // Store commits on the last BUSY edge, and never for an erroring request
    assign mem_we = (state_reg == BUSY) && (cnt_reg == '0) && write_reg && !err_reg;

    mem_word_array #(
        .DEPTH (DEPTH)
    ) u_mem_word_array (
        .clk   (clk),
        .we    (mem_we),
        .index (index_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    // Request/latency/response FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            write_reg      <= 1'b0;
            index_reg      <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_error_reg <= RESP_OK;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        index_reg <= req_index;
                        wdata_reg <= req_wdata;
                        err_reg   <= req_err;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= err_reg ? RESP_ERR : RESP_OK;
                        resp_rdata_reg <= (write_reg || err_reg) ? '0 : mem_rdata;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= '0;
                        resp_error_reg <= RESP_OK;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses LATENCY=2,
// instance 1 uses LATENCY=1. Expected responses are queued at request
// acceptance and checked by a negedge monitor when the DUT responds.
module tb_data_mem_responder;

    localparam int NDUT  = 2;
    localparam int BOUND = 50;

    logic        clk;
    logic        rst;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_write  [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [31:0] resp_rdata [NDUT];
    logic        resp_error [NDUT];

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] mdl [NDUT][256];
    bit          seen [NDUT];
    int          last_acc [NDUT];
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          raise_cyc;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        data_mem_responder #(
            .DEPTH   (256),
            .LATENCY ((gi == 0) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_write  (req_write[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_error (resp_error[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response monitor: compare against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                if (resp_valid[d]) begin
                    check_val("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
                    if (sb_q.size() == 0) begin
                        check_val("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        sb_t e;
                        e = sb_q[0];
                        check_val("resp_dut", 32'(d), 32'(e.dut));
                        if (!seen[d]) begin
                            check_val("latency", 32'(cyc - e.acc), 32'(lat_of(d)));
                            seen[d] = 1'b1;
                        end
                        check_val("resp_rdata", resp_rdata[d], e.rdata);
                        check_val("resp_error", 32'(resp_error[d]), 32'(e.err));
                        if (resp_ready[d]) begin
                            void'(sb_q.pop_front());
                            seen[d] = 1'b0;
                            if (e.wr && !e.err) mdl[d][e.addr[9:2]] = e.wdata;
                            $display("resp dut=%0d %s addr=0x%08h rdata=0x%08h err=%0d",
                                     d, e.wr ? "st" : "ld", e.addr, resp_rdata[d], resp_error[d]);
                        end
                    end
                end
            end
        end
    end

    // Drive one request and return just after the edge that accepts it
    task automatic do_req(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        sb_t e;
        int  k;
        e.dut   = d;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        e.rdata = (wr || e.err) ? 32'd0 : mdl[d][addr[9:2]];
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready[d] && k < BOUND);
        if (!req_ready[d]) begin
            check_val("accept_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        last_acc[d]  = e.acc;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check_val({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
            check_val({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
            check_val({tag, "_resp_rdata"}, resp_rdata[d],      32'd0);
            check_val({tag, "_resp_error"}, 32'(resp_error[d]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            resp_ready[d] = 1'b1;
            seen[d]       = 1'b0;
            last_acc[d]   = 0;
        end

        // Asynchronous reset asserted mid-cycle, checked before any edge
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_reset");
        @(posedge clk);
        #1;

        // Store/load round trip
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF); wait_drain();
        do_req(0, 1'b0, 32'h10, 32'h0);        wait_drain();

        // Misaligned and out-of-range requests must not touch storage
        do_req(0, 1'b1, 32'h13,  32'h12345678); wait_drain();
        do_req(0, 1'b1, 32'h410, 32'h5555AAAA); wait_drain();
        do_req(0, 1'b0, 32'h10,  32'h0);        wait_drain();
        do_req(0, 1'b0, 32'h400, 32'h0);        wait_drain();
        do_req(0, 1'b0, 32'h3FC, 32'h0);        wait_drain();

        // Backpressure: hold the response, present a new request meanwhile
        do_req(0, 1'b1, 32'h4, 32'h0BADF00D); wait_drain();
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 32'h4, 32'h0);
        fork
            do_req(0, 1'b0, 32'h10, 32'h0);
            begin
                int k;
                k = 0;
                while (!resp_valid[0] && k < BOUND) begin
                    @(negedge clk);
                    k++;
                end
                check_val("bp_resp_seen", 32'(resp_valid[0]), 32'd1);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1;
                resp_ready[0] = 1'b1;
                raise_cyc = cyc;
            end
        join
        check_val("bp_accept_delay", 32'(last_acc[0] - raise_cyc), 32'd2);
        wait_drain();

        // Reset while a store is in BUSY drops the store
        do_req(0, 1'b1, 32'h20, 32'h0); wait_drain();
        do_req(0, 1'b1, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb_q.delete();
        for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;
        #1;
        check_val("mid_reset_req_ready",  32'(req_ready[0]),  32'd1);
        check_val("mid_reset_resp_valid", 32'(resp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid_reset_no_resp", 32'(resp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 32'h20, 32'h0); wait_drain();

        // Back-to-back loads on the LATENCY=1 instance
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b1, 32'(i * 4), 32'hA5A50000 + 32'(i * 17));
            wait_drain();
        end
        begin
            int prev;
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                do_req(1, 1'b0, 32'(i * 4), 32'h0);
                if (i > 0) check_val("stream_spacing", 32'(last_acc[1] - prev), 32'd3);
                prev = last_acc[1];
            end
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's load/store port: the processor is the initiator, and this block services its word-sized reads and writes.
- Replaces the combinational data memory with a valid/ready request channel, a valid/ready response channel and a configurable access latency.
- Sits between the ALU result / ReadData2 path of the multi-cycle core and the word storage array.

Parameters:
- DEPTH, 256, number of 32-bit words stored (power of two, >=4).
- LATENCY, 2, clock edges from request acceptance to resp_valid rising (>=1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data (0 for stores and errors).
- resp_error  output  1  request was misaligned or out of range.

Behaviour:
- Reset (async, active-high): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0. Storage contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - When req_valid & req_ready at a clock edge: latch write, addr, wdata and the error flag; load counter=LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - If counter!=0, decrement it.
  - If counter==0, perform the access and go to RESP. A store writes the word only if there is no error. A load sets resp_rdata=mem[index], or 0 on error. Set resp_error to the latched flag and resp_valid=1.
- RESP:
  - req_ready=0.
  - resp_valid, resp_rdata and resp_error are held stable until resp_valid & resp_ready at an edge.
  - On that edge: resp_valid=0, resp_rdata=0, resp_error=0, go to IDLE.
- Latency: acceptance at edge N gives resp_valid high after edge N+LATENCY. With resp_ready tied high, the next acceptance is possible at edge N+LATENCY+2.
- Addressing:
  - index = req_addr[log2(DEPTH)+1:2].
  - error = (req_addr[1:0]!=0) | (req_addr[31:log2(DEPTH)+2]!=0).
  - An erroring request still takes full latency and never modifies storage.
- Ordering: a load issued after a completed store to the same address returns the stored value.
- Requests presented while req_ready=0 are ignored. The initiator must hold them; the responder does not queue them.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - A store still in BUSY is dropped; storage is unchanged.
  - A pending response is discarded.
- req_ready is a decode of state==IDLE. All other outputs are registered.
- Counter width: clog2(LATENCY) bits, minimum 1.

Decomposition:
- Shared package mips_mem_pkg:
  - WORD_W=32.
  - State encoding constants IDLE/BUSY/RESP.
  - Response error code constant.
- Sub-module mem_word_array: DEPTH x 32 storage with a synchronous write port (we, index, wdata) and a combinational read port, instantiated once.
- The FSM, counter and error check stay in data_mem_responder.

Test Plan:
- Reset then idle:
  - Assert rst mid-cycle (async): req_ready=1, resp_valid=0, resp_rdata=0 immediately.
  - Release rst: outputs unchanged with no request.
- Store/load round trip, LATENCY=2:
  - Store 0xDEADBEEF to addr 0x10: resp_valid rises 2 edges after acceptance, resp_rdata=0, resp_error=0.
  - Load 0x10: resp_rdata=0xDEADBEEF.
- Misaligned and out-of-range:
  - Store 0x12345678 to addr 0x13: resp_error=1.
  - Load 0x10: still returns 0xDEADBEEF.
  - Load addr 0x400 (DEPTH=256): resp_error=1, resp_rdata=0.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after resp_valid: rdata/error stable and req_ready=0 throughout.
  - A new req_valid during that time is not accepted.
  - Raise resp_ready: the held request is accepted 2 edges later.
- Reset mid-access:
  - Store 0xCAFEF00D to addr 0x20; assert rst one cycle after acceptance (in BUSY).
  - Load 0x20 after reset: returns the prior contents (write 0x0 first to make it deterministic), not 0xCAFEF00D.
- Back-to-back throughput, LATENCY=1, resp_ready=1:
  - Stream 4 loads at addresses 0x0, 0x4, 0x8, 0xC: accepts every 3 edges.
  - Responses arrive in order with the previously stored values.
